// File: rtl/scale_factor_queue.sv
// Width-converting scale-factor FIFO: stores wide AXI read beats and replays
// them as narrow words, one per output handshake, in arrival order.
module scale_factor_queue #(
    parameter int WRITE_WIDTH = 512,
    parameter int WRITE_DEPTH = 64,
    parameter int READ_WIDTH  = 32,
    parameter int READ_DEPTH  = WRITE_DEPTH * WRITE_WIDTH / READ_WIDTH,
    parameter int WPB         = WRITE_WIDTH / READ_WIDTH
) (
    input  logic                            core_clk,
    input  logic                            resetn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WRITE_WIDTH-1:0]          in_data,
    input  logic [$clog2(WPB):0]            in_words,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [READ_WIDTH-1:0]           out_data,
    output logic                            out_last,
    input  logic                            flush,
    output logic [$clog2(READ_DEPTH):0]     word_count,
    output logic                            empty,
    output logic                            full
);
    localparam int PTR_W = $clog2(WRITE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WI_W  = $clog2(WPB);
    localparam int IW    = WI_W + 1;
    localparam int WC_W  = $clog2(READ_DEPTH) + 1;

    // Handshakes: a transfer happens on a clock edge where valid && ready are
    // both high; valid never depends on ready, and in_ready depends only on
    // registered occupancy, so neither side has a combinational loop.

    logic [WRITE_WIDTH-1:0] mem_data  [WRITE_DEPTH];
    logic [IW-1:0]          mem_words [WRITE_DEPTH];
    logic                   mem_last  [WRITE_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [WI_W-1:0]  widx_q, widx_d;
    logic [WC_W-1:0]  word_count_q, word_count_d;

    logic                   push;
    logic                   pop;
    logic                   at_tail;
    logic [IW-1:0]          in_eff;
    logic [WRITE_WIDTH-1:0] head_data;
    logic [IW-1:0]          head_words;
    logic                   head_last;

    assign full      = (beats_q == CNT_W'(WRITE_DEPTH));
    assign empty     = (beats_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;

    assign push   = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    // A word count of zero on the input side encodes a completely filled beat.
    assign in_eff = (in_words == '0) ? IW'(WPB) : in_words;

    assign head_data  = mem_data[rd_ptr_q];
    assign head_words = mem_words[rd_ptr_q];
    assign head_last  = mem_last[rd_ptr_q];
    assign at_tail    = ({1'b0, widx_q} == (head_words - IW'(1)));

    assign out_data   = out_valid ? head_data[READ_WIDTH*int'(widx_q) +: READ_WIDTH] : '0;
    assign out_last   = out_valid && head_last && at_tail;
    assign word_count = word_count_q;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        beats_d      = beats_q;
        widx_d       = widx_q;
        word_count_d = word_count_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            beats_d      = '0;
            widx_d       = '0;
            word_count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(WRITE_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                if (at_tail) begin
                    widx_d   = '0;
                    rd_ptr_d = (rd_ptr_q == PTR_W'(WRITE_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end else begin
                    widx_d = widx_q + WI_W'(1);
                end
            end
            beats_d      = beats_q + CNT_W'(push) - CNT_W'(pop && at_tail);
            word_count_d = word_count_q + (push ? WC_W'(in_eff) : '0) - WC_W'(pop);
        end
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            beats_q      <= '0;
            widx_q       <= '0;
            word_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            beats_q      <= beats_d;
            widx_q       <= widx_d;
            word_count_q <= word_count_d;
        end
    end

    // Storage has no reset; an entry is only read once its beat is counted.
    always_ff @(posedge core_clk) begin
        if (push && !flush) begin
            mem_data[wr_ptr_q]  <= in_data;
            mem_words[wr_ptr_q] <= in_eff;
            mem_last[wr_ptr_q]  <= in_last;
        end
    end
endmodule

// File: doc/scale_factor_queue.md
# scale_factor_queue

Width-converting FIFO for scale factors fetched by the prefetcher with opcode `SCALE_FACTOR`. It accepts 512-bit AXI read beats and stores up to 64 beats. It replays their contents as 32-bit words, one per handshake, to the aggregation engine for `WEIGHTED_SUM` aggregation. It sits between the prefetcher's AXI read path and the aggregation core.

## Interface
Parameters:
- `WRITE_WIDTH`, 512: input beat width in bits (`SCALE_FACTOR_QUEUE_WRITE_WIDTH`).
- `WRITE_DEPTH`, 64: beat storage entries (`SCALE_FACTOR_QUEUE_WRITE_DEPTH`).
- `READ_WIDTH`, 32: output word width (`SCALE_FACTOR_QUEUE_READ_WIDTH`).
- `READ_DEPTH`, 1024: maximum stored words, equal to `WRITE_DEPTH*WRITE_WIDTH/READ_WIDTH`.
- Derived `WPB = WRITE_WIDTH/READ_WIDTH` (16).

Ports:
- `core_clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  queue can accept a beat.
- `in_data`  in  WRITE_WIDTH  beat payload; word k is `in_data[32k+31:32k]`.
- `in_words`  in  $clog2(WPB)+1  valid words in the beat, counted from word 0. A value of 0 means WPB.
- `in_last`  in  1  beat ends the scale-factor request.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  READ_WIDTH  current word.
- `out_last`  out  1  final word of a beat that had `in_last` set.
- `flush`  in  1  synchronous clear.
- `word_count`  out  $clog2(READ_DEPTH)+1  stored words not yet popped.
- `empty`  out  1  no beats stored.
- `full`  out  1  WRITE_DEPTH beats stored.

## Operation
- Storage is a circular buffer of WRITE_DEPTH entries. Each entry holds `{data, words, last}`.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are $clog2(WRITE_DEPTH) bits wide. The beat count `beats` is $clog2(WRITE_DEPTH)+1 bits wide.
- Within the head beat, the word index `widx` is $clog2(WPB) bits wide.
- Push occurs when `in_valid && in_ready`:
  - The entry is written at `wr_ptr`.
  - `wr_ptr` increments and wraps from WRITE_DEPTH-1 to 0.
  - `beats` increments.
- Pop occurs when `out_valid && out_ready`:
  - If `widx == head.words-1`, then `widx` returns to 0, `rd_ptr` increments with wrap, and `beats` decrements.
  - Otherwise `widx` increments.
- `out_valid = (beats != 0)`.
- `out_data = head.data[32*widx +: 32]` when `out_valid` is high, and 0 otherwise.
- `out_last = out_valid && head.last && (widx == head.words-1)`.
- `in_ready = (beats != WRITE_DEPTH)`. There is no combinational path from `out_ready` to `in_ready`, so a full queue does not accept a beat in the same cycle as a pop.
- `full = (beats == WRITE_DEPTH)`; `empty = (beats == 0)`.
- `word_count` update:
  - Increases by the effective `in_words` (0 counts as WPB) on a push.
  - Decreases by 1 on a pop.
  - Both apply in the same cycle when push and pop coincide.
- Simultaneous push and pop of a head beat's final word leaves `beats` unchanged. The pointers still advance.
- Flush:
  - `flush` high at a clock edge clears `wr_ptr`, `rd_ptr`, `beats`, `widx` and `word_count`.
  - Flush has priority over a push and a pop in the same cycle; both are discarded.
  - Memory contents are not cleared.
- Entries are never overwritten while occupied. Memory data content is unconstrained after reset.

## Timing
- Reset values (while `resetn` is low, asynchronously):
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0.
  - `word_count`=0, `empty`=1, `full`=0.
  - Internal pointers and `widx` are 0.
- Write-to-read latency is 1 cycle: a beat pushed at edge N makes `out_valid` high after edge N. The first word can be popped at edge N+1.
- Throughput is one word popped per cycle and one beat pushed per cycle, sustained.
- Output handshake rule: `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- Input handshake rule: a beat offered with `in_ready` low is not written, and the upstream holds it.
- All flags (`full`, `empty`, `word_count`) are registered state or derived directly from registered state. They change only after a clock edge.
- Reset asserted mid-transfer drops all stored beats. The queue resumes empty when reset is released.

## Test plan
- Single beat `in_data` word k = k+1, `in_words`=16, `in_last`=1, `out_ready`=1 -> words 1..16 on consecutive cycles. `out_last` is high only with word 16. `word_count` goes 16→0 and `empty` returns to 1.
- Partial beat, `in_words`=3 with words 0xA, 0xB, 0xC, followed by a full beat -> outputs are 0xA, 0xB, 0xC, then the second beat's word 0 with no gap. `word_count` peaks at 19.
- Fill to 64 beats with `out_ready`=0 -> `full`=1 and `in_ready`=0 after the 64th push, and `word_count`=1024. A 65th offered beat is not accepted. After one complete beat is popped, `in_ready` returns to 1 on the next cycle.
- Wrap-around with continuous push and pop over 200 beats, each beat's words tagged with the beat number -> strict in-order output across the pointer wrap, with no loss or duplication.
- Assert `flush` together with `in_valid` and `out_ready` while 5 beats are stored -> on the next cycle `empty`=1 and `word_count`=0, and the flushed-cycle beat is not stored.
- Assert `resetn` low asynchronously mid-beat, at word 7 of 16 -> `out_valid`=0 and `word_count`=0 immediately. After release, a new beat is output starting from word 0.
